// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg
//   Shared definitions for the two-master Wishbone arbiter:
//   grant encoding, default bus widths and the tie-break helper.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_M0   = 2'd1,
        GNT_M1   = 2'd2
    } gnt_t;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    // Pick a new owner from the current cyc requests.
    // prefer_m1 only matters when both masters request together.
    function automatic gnt_t arbitrate(input logic m0_cyc,
                                       input logic m1_cyc,
                                       input logic prefer_m1);
        gnt_t pick;
        pick = GNT_NONE;
        if (m0_cyc && m1_cyc)
            pick = prefer_m1 ? GNT_M1 : GNT_M0;
        else if (m0_cyc)
            pick = GNT_M0;
        else if (m1_cyc)
            pick = GNT_M1;
        return pick;
    endfunction

endpackage

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m
//   Two-master to one-slave classic Wishbone arbiter. A registered grant
//   selects the owner; the owner keeps the bus until it drops cyc, and the
//   release edge re-arbitrates immediately (no idle cycle on handover).
//   Once granted, request and return paths are purely combinational.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   i_m0_* / o_m0_*       : master 0 request inputs, ack/data/int returns
//   i_m1_* / o_m1_*       : master 1, same set
//   o_s_*                 : request towards the slave (all 0 when no owner)
//   i_s_dat/ack/int       : slave returns; int is broadcast to both masters
//
// Build option
//   WB_ARB_ROUND_ROBIN_EN : when defined, a tie goes to the master that was
//                           not the last owner (last owner resets to m1).
//                           Otherwise m0 wins every tie.
module wb_arbiter_2m
    import wb_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = wb_arb_pkg::DATA_WIDTH,
    parameter  int ADDR_WIDTH = wb_arb_pkg::ADDR_WIDTH,
    localparam int SEL_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_m0_we,
    input  logic                  i_m0_stb,
    input  logic                  i_m0_cyc,
    input  logic [SEL_WIDTH-1:0]  i_m0_sel,
    input  logic [DATA_WIDTH-1:0] i_m0_dat,
    input  logic [ADDR_WIDTH-1:0] i_m0_adr,
    output logic [DATA_WIDTH-1:0] o_m0_dat,
    output logic                  o_m0_ack,
    output logic                  o_m0_int,

    input  logic                  i_m1_we,
    input  logic                  i_m1_stb,
    input  logic                  i_m1_cyc,
    input  logic [SEL_WIDTH-1:0]  i_m1_sel,
    input  logic [DATA_WIDTH-1:0] i_m1_dat,
    input  logic [ADDR_WIDTH-1:0] i_m1_adr,
    output logic [DATA_WIDTH-1:0] o_m1_dat,
    output logic                  o_m1_ack,
    output logic                  o_m1_int,

    output logic                  o_s_we,
    output logic                  o_s_stb,
    output logic                  o_s_cyc,
    output logic [SEL_WIDTH-1:0]  o_s_sel,
    output logic [DATA_WIDTH-1:0] o_s_dat,
    output logic [ADDR_WIDTH-1:0] o_s_adr,
    input  logic [DATA_WIDTH-1:0] i_s_dat,
    input  logic                  i_s_ack,
    input  logic                  i_s_int
);

    gnt_t grant;
    gnt_t grant_next;
    logic prefer_m1;

`ifdef WB_ARB_ROUND_ROBIN_EN
    // 1 = m1 owned the bus last; updated on the owner's release edge.
    logic last_m1;

    always_ff @(posedge clk) begin
        if (rst)
            last_m1 <= 1'b1;
        else if (grant == GNT_M0 && !i_m0_cyc)
            last_m1 <= 1'b0;
        else if (grant == GNT_M1 && !i_m1_cyc)
            last_m1 <= 1'b1;
    end

    assign prefer_m1 = ~last_m1;
`else
    assign prefer_m1 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            grant <= GNT_NONE;
        else
            grant <= grant_next;
    end

    // An owner holding cyc keeps the bus; on release the same edge
    // re-arbitrates so a waiting master takes over with no idle cycle.
    always_comb begin
        grant_next = grant;
        case (grant)
            GNT_M0:  if (!i_m0_cyc) grant_next = arbitrate(i_m0_cyc, i_m1_cyc, prefer_m1);
            GNT_M1:  if (!i_m1_cyc) grant_next = arbitrate(i_m0_cyc, i_m1_cyc, prefer_m1);
            default: grant_next = arbitrate(i_m0_cyc, i_m1_cyc, prefer_m1);
        endcase
    end

    always_comb begin
        o_s_we   = 1'b0;
        o_s_stb  = 1'b0;
        o_s_cyc  = 1'b0;
        o_s_sel  = '0;
        o_s_dat  = '0;
        o_s_adr  = '0;
        o_m0_ack = 1'b0;
        o_m0_dat = '0;
        o_m1_ack = 1'b0;
        o_m1_dat = '0;
        case (grant)
            GNT_M0: begin
                o_s_we   = i_m0_we;
                o_s_stb  = i_m0_stb;
                o_s_cyc  = i_m0_cyc;
                o_s_sel  = i_m0_sel;
                o_s_dat  = i_m0_dat;
                o_s_adr  = i_m0_adr;
                o_m0_ack = i_s_ack;
                o_m0_dat = i_s_dat;
            end
            GNT_M1: begin
                o_s_we   = i_m1_we;
                o_s_stb  = i_m1_stb;
                o_s_cyc  = i_m1_cyc;
                o_s_sel  = i_m1_sel;
                o_s_dat  = i_m1_dat;
                o_s_adr  = i_m1_adr;
                o_m1_ack = i_s_ack;
                o_m1_dat = i_s_dat;
            end
            default: ;
        endcase
    end

    assign o_m0_int = i_s_int;
    assign o_m1_int = i_s_int;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m
//   Directed bench for wb_arbiter_2m with hand-computed expectations.
//   Inputs change 1 time unit after a rising edge; outputs are checked
//   another unit later, well away from the next edge.
module tb_wb_arbiter_2m;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_m0_we, i_m0_stb, i_m0_cyc;
    logic [SW-1:0] i_m0_sel;
    logic [DW-1:0] i_m0_dat;
    logic [AW-1:0] i_m0_adr;
    logic [DW-1:0] o_m0_dat;
    logic          o_m0_ack, o_m0_int;
    logic          i_m1_we, i_m1_stb, i_m1_cyc;
    logic [SW-1:0] i_m1_sel;
    logic [DW-1:0] i_m1_dat;
    logic [AW-1:0] i_m1_adr;
    logic [DW-1:0] o_m1_dat;
    logic          o_m1_ack, o_m1_int;
    logic          o_s_we, o_s_stb, o_s_cyc;
    logic [SW-1:0] o_s_sel;
    logic [DW-1:0] o_s_dat;
    logic [AW-1:0] o_s_adr;
    logic [DW-1:0] i_s_dat;
    logic          i_s_ack, i_s_int;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    wb_arbiter_2m #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .i_m0_we(i_m0_we), .i_m0_stb(i_m0_stb), .i_m0_cyc(i_m0_cyc),
        .i_m0_sel(i_m0_sel), .i_m0_dat(i_m0_dat), .i_m0_adr(i_m0_adr),
        .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack), .o_m0_int(o_m0_int),
        .i_m1_we(i_m1_we), .i_m1_stb(i_m1_stb), .i_m1_cyc(i_m1_cyc),
        .i_m1_sel(i_m1_sel), .i_m1_dat(i_m1_dat), .i_m1_adr(i_m1_adr),
        .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack), .o_m1_int(o_m1_int),
        .o_s_we(o_s_we), .o_s_stb(o_s_stb), .o_s_cyc(o_s_cyc),
        .o_s_sel(o_s_sel), .o_s_dat(o_s_dat), .o_s_adr(o_s_adr),
        .i_s_dat(i_s_dat), .i_s_ack(i_s_ack), .i_s_int(i_s_int)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_m0(input logic cyc, input logic stb, input logic we,
                            input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                            input logic [SW-1:0] sel);
        i_m0_cyc = cyc; i_m0_stb = stb; i_m0_we = we;
        i_m0_adr = adr; i_m0_dat = dat; i_m0_sel = sel;
    endtask

    task automatic drive_m1(input logic cyc, input logic stb, input logic we,
                            input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                            input logic [SW-1:0] sel);
        i_m1_cyc = cyc; i_m1_stb = stb; i_m1_we = we;
        i_m1_adr = adr; i_m1_dat = dat; i_m1_sel = sel;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] tie_adr;

        rst = 1'b1;
        drive_m0(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive_m1(1'b0, 1'b0, 1'b0, '0, '0, '0);
        i_s_dat = 32'h5A5A_A5A5;
        i_s_ack = 1'b1;
        i_s_int = 1'b0;
        do_reset();
        settle();

        // Idle after reset: nothing leaks through, even with slave ack/data live.
        check("rst_s_cyc", o_s_cyc, 0);
        check("rst_s_stb", o_s_stb, 0);
        check("rst_s_we",  o_s_we,  0);
        check("rst_s_adr", o_s_adr, 0);
        check("rst_s_dat", o_s_dat, 0);
        check("rst_s_sel", o_s_sel, 0);
        check("rst_m0_ack", o_m0_ack, 0);
        check("rst_m1_ack", o_m1_ack, 0);
        check("rst_m0_dat", o_m0_dat, 0);
        check("rst_m1_dat", o_m1_dat, 0);
        i_s_ack = 1'b0;
        i_s_int = 1'b1;
        settle();
        check("int_m0", o_m0_int, 1);
        check("int_m1", o_m1_int, 1);
        i_s_int = 1'b0;
        settle();
        check("int_m0_low", o_m0_int, 0);

        // stb without cyc does not request the bus.
        drive_m0(1'b0, 1'b1, 1'b1, 32'h44, 32'h1, 4'hF);
        tick();
        settle();
        check("stb_only_cyc", o_s_cyc, 0);
        check("stb_only_stb", o_s_stb, 0);

        // m0 write DEADBEEF to 0x10: reaches slave one cycle after cyc.
        drive_m0(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        settle();
        check("wr_pre_cyc", o_s_cyc, 0);
        tick();
        settle();
        check("wr_cyc", o_s_cyc, 1);
        check("wr_stb", o_s_stb, 1);
        check("wr_we",  o_s_we,  1);
        check("wr_adr", o_s_adr, 32'h10);
        check("wr_dat", o_s_dat, 32'hDEAD_BEEF);
        check("wr_sel", o_s_sel, 4'hF);
        i_s_ack = 1'b1;
        settle();
        check("wr_m0_ack", o_m0_ack, 1);
        check("wr_m1_ack", o_m1_ack, 0);
        tick();

        // Read back on the same ownership.
        drive_m0(1'b1, 1'b1, 1'b0, 32'h10, '0, 4'hF);
        i_s_dat = 32'hDEAD_BEEF;
        settle();
        check("rd_we", o_s_we, 0);
        check("rd_m0_dat", o_m0_dat, 32'hDEAD_BEEF);
        check("rd_m1_dat", o_m1_dat, 0);
        check("rd_m0_ack", o_m0_ack, 1);
        tick();
        i_s_ack = 1'b0;
        drive_m0(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        settle();
        check("rd_release", o_s_cyc, 0);

        // Tie from idle after reset: m0 first in both builds.
        do_reset();
        drive_m0(1'b1, 1'b1, 1'b0, 32'h20, '0, 4'h1);
        drive_m1(1'b1, 1'b1, 1'b1, 32'h30, 32'h1234, 4'h2);
        tick();
        settle();
        check("tie1_adr", o_s_adr, 32'h20);
        // m0 releases, m1 takes over on that same edge.
        drive_m0(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        settle();
        check("hand_cyc", o_s_cyc, 1);
        check("hand_adr", o_s_adr, 32'h30);
        check("hand_sel", o_s_sel, 4'h2);
        i_s_ack = 1'b1;
        i_s_dat = 32'hCAFE_0001;
        settle();
        check("hand_m1_ack", o_m1_ack, 1);
        check("hand_m0_ack", o_m0_ack, 0);
        check("hand_m1_dat", o_m1_dat, 32'hCAFE_0001);
        check("hand_m0_dat", o_m0_dat, 0);
        i_s_ack = 1'b0;
        drive_m1(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        settle();
        check("hand_idle", o_s_cyc, 0);

        // Tie again: m1 was last owner, so m0 wins in both builds.
        drive_m0(1'b1, 1'b1, 1'b0, 32'h20, '0, 4'h1);
        drive_m1(1'b1, 1'b1, 1'b0, 32'h30, '0, 4'h2);
        tick();
        settle();
        check("tie2_adr", o_s_adr, 32'h20);
        // Both drop: m0 released last, then tie once more.
        drive_m0(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive_m1(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        drive_m0(1'b1, 1'b1, 1'b0, 32'h20, '0, 4'h1);
        drive_m1(1'b1, 1'b1, 1'b0, 32'h30, '0, 4'h2);
        tick();
        settle();
`ifdef WB_ARB_ROUND_ROBIN_EN
        tie_adr = 32'h30;
`else
        tie_adr = 32'h20;
`endif
        check("tie3_adr", o_s_adr, tie_adr);
        drive_m0(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive_m1(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        tick();

        // m1 owns for 5 transfers while m0 waits.
        drive_m1(1'b1, 1'b1, 1'b0, 32'h100, '0, 4'hF);
        tick();
        drive_m0(1'b1, 1'b1, 1'b1, 32'h200, 32'hA5, 4'hF);
        i_s_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i_m1_adr = 32'h100 + 32'(i * 4);
            settle();
            check("starve_adr", o_s_adr, 32'h100 + 32'(i * 4));
            check("starve_m0_ack", o_m0_ack, 0);
            check("starve_m1_ack", o_m1_ack, 1);
            tick();
        end
        i_s_ack = 1'b0;
        drive_m1(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        settle();
        check("after_m1_cyc", o_s_cyc, 1);
        check("after_m1_adr", o_s_adr, 32'h200);
        check("after_m1_dat", o_s_dat, 32'hA5);

        // Reset while m1 owns with stb high.
        drive_m0(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        drive_m1(1'b1, 1'b1, 1'b1, 32'h300, 32'h77, 4'hF);
        tick();
        settle();
        check("pre_rst_cyc", o_s_cyc, 1);
        rst = 1'b1;
        i_s_ack = 1'b1;
        tick();
        settle();
        check("mid_rst_cyc", o_s_cyc, 0);
        check("mid_rst_stb", o_s_stb, 0);
        check("mid_rst_m1_ack", o_m1_ack, 0);
        rst = 1'b0;
        drive_m1(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        settle();
        check("post_rst_cyc", o_s_cyc, 0);
        check("post_rst_m1_ack", o_m1_ack, 0);
        drive_m1(1'b1, 1'b1, 1'b0, 32'h304, '0, 4'hF);
        settle();
        check("post_rst_req_pending", o_s_cyc, 0);
        tick();
        settle();
        check("post_rst_regrant", o_s_cyc, 1);
        check("post_rst_m1_ack2", o_m1_ack, 1);
        i_s_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master to one-slave Wishbone (classic, single-cycle handshake) arbiter.
- Lets a memory-side DMA master (m1) and the memory interconnect (m0) share one Wishbone slave, typically a block RAM.
- A registered grant selects one owner. The owner keeps the bus until it drops cyc.
- The non-owner sees no ack and zero read data until it is granted.

Parameters:
- DATA_WIDTH, 32, width of the data buses.
- ADDR_WIDTH, 32, width of the address buses.
- SEL_WIDTH, DATA_WIDTH/8, byte-select width (derived; not overridden).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_m0_we/i_m0_stb/i_m0_cyc  in  1 each  master 0 write-enable, strobe, cycle.
- i_m0_sel  in  SEL_WIDTH  master 0 byte selects.
- i_m0_dat  in  DATA_WIDTH  master 0 write data.
- i_m0_adr  in  ADDR_WIDTH  master 0 address.
- o_m0_dat  out  DATA_WIDTH  read data to master 0.
- o_m0_ack  out  1  ack to master 0.
- o_m0_int  out  1  interrupt to master 0.
- i_m1_*, o_m1_*: same set of ports for master 1.
- o_s_we/o_s_stb/o_s_cyc  out  1 each  slave write-enable, strobe, cycle.
- o_s_sel  out  SEL_WIDTH  slave byte selects.
- o_s_dat  out  DATA_WIDTH  slave write data.
- o_s_adr  out  ADDR_WIDTH  slave address.
- i_s_dat  in  DATA_WIDTH  slave read data.
- i_s_ack  in  1  slave ack.
- i_s_int  in  1  slave interrupt.

Behaviour:
- Grant register states: NONE, M0, M1. Reset (synchronous) forces NONE.
- Transitions, evaluated each rising edge:
  - NONE: i_m0_cyc -> M0; else i_m1_cyc -> M1; else stay NONE. Both cyc high -> M0 (fixed priority).
  - M0: stay while i_m0_cyc=1. When i_m0_cyc=0, re-arbitrate in the same edge using the NONE rules. Back-to-back handover with zero idle cycles is allowed.
  - M1: symmetric to M0.
- Slave outputs (combinational mux from the grant register):
  - Granted: o_s_we/stb/cyc/sel/dat/adr equal the owner's inputs.
  - NONE: all slave outputs are 0.
- Return path:
  - Owner: o_mX_ack = i_s_ack, o_mX_dat = i_s_dat.
  - Non-owner: ack = 0, dat = 0.
- o_m0_int and o_m1_int both equal i_s_int at all times, independent of grant.
- Latency: a request from idle reaches the slave one cycle after the master raises cyc. Once granted, the path is combinational with zero added latency. The ack the slave produces is passed through combinationally.
- Reset values: grant NONE, so all o_s_* = 0 and o_m0_ack = o_m1_ack = 0, o_m0_dat = o_m1_dat = 0. o_mX_int follows i_s_int.
- Reset during a transfer: the grant drops to NONE at that edge. The slave sees cyc/stb = 0 the same cycle the reset takes effect, and no ack reaches any master afterward.
- stb without cyc is ignored for arbitration; only cyc requests the bus.
- The arbiter never preempts: an owner holding cyc high indefinitely starves the other master.

Optional Feature:
- Macro: WB_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-owner register, reset to M1, is set whenever an owner releases the bus. On a tie from NONE or during handover, the master that was not the last owner wins.
- Undefined: fixed priority, m0 wins ties.
- All other behaviour is identical in both builds.

Decomposition:
- Package wb_arb_pkg holds:
  - the grant enum (GNT_NONE, GNT_M0, GNT_M1);
  - the default widths DATA_WIDTH and ADDR_WIDTH.
- Single module. The next-grant logic is small enough to keep inline; no sub-module.

Test Plan:
- After reset, idle: all o_s_* = 0, o_m0_ack = 0, o_m1_ack = 0. Drive i_s_int = 1 -> o_m0_int = 1 and o_m1_int = 1.
- m0 writes 0xDEADBEEF to adr 0x10, sel 0xF:
  - slave sees stb/we/adr/dat one cycle after cyc;
  - slave ack routes to o_m0_ack only;
  - read back returns 0xDEADBEEF on o_m0_dat; o_m1_dat stays 0.
- Both masters raise cyc in the same cycle:
  - without the macro: m0 granted first;
  - m1 granted on the edge after m0 drops cyc, with no idle cycle between;
  - with the macro: the first grant goes to m0 (last-owner reset to M1), and the next tie after m0 releases goes to m1.
- m1 owns the bus and holds cyc for 5 transfers while m0 requests: m0 sees ack = 0 throughout; m0 is granted the cycle after m1 releases.
- Assert rst while m1 owns the bus with stb = 1: the next cycle has o_s_cyc = 0 and o_m1_ack = 0, and the grant is NONE until a new request.
